// File: rtl/card_dealer_pkg.sv
// Shared deck constants and dealer state encoding for the card dealer
// and for the display/score logic that reuses card_decode.
package card_dealer_pkg;
    localparam int DECK_SIZE = 52;
    localparam int RANKS     = 13;
    localparam int SUITS     = 4;
    localparam int ADDR_W    = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        PROBE = 2'd2,
        DEAL  = 2'd3
    } state_t;

    // Mirror a 6-bit value so low counter bits, which change fastest, land in the MSBs.
    function automatic logic [ADDR_W-1:0] bit_rev6(input logic [ADDR_W-1:0] v);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = v[ADDR_W-1-i];
        end
        return r;
    endfunction
endpackage

// File: rtl/card_decode.sv
// Combinational card address -> rank (1..13) / suit (0..3) decoder.
module card_decode
    import card_dealer_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    output logic [3:0]        o_rank,
    output logic [1:0]        o_suit
);
    logic [ADDR_W-1:0] w_base;

    always_comb begin
        w_base = '0;
        o_suit = 2'd0;
        if (i_addr >= ADDR_W'(3 * RANKS)) begin
            w_base = ADDR_W'(3 * RANKS);
            o_suit = 2'd3;
        end else if (i_addr >= ADDR_W'(2 * RANKS)) begin
            w_base = ADDR_W'(2 * RANKS);
            o_suit = 2'd2;
        end else if (i_addr >= ADDR_W'(RANKS)) begin
            w_base = ADDR_W'(RANKS);
            o_suit = 2'd1;
        end
    end

    assign o_rank = 4'(i_addr - w_base + 6'd1);
endmodule

// File: rtl/card_dealer.sv
// Draws cards from a 52-card deck without repetition using a scrambled
// step from a free-running counter plus linear probing over dealt cards.
module card_dealer #(
    parameter int CNT_W     = 12,
    parameter int DECK_SIZE = 52
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       New_Deck,
    input  logic       Draw_Req,
    output logic       Card_Valid,
    output logic [5:0] Card_Addr,
    output logic [3:0] Card_Rank,
    output logic [1:0] Card_Suit,
    output logic [5:0] Cards_Left,
    output logic       Deck_Empty,
    output logic       Busy,
    output logic       Draw_Err
);
    import card_dealer_pkg::*;

    localparam logic [5:0] LAST_A = 6'(DECK_SIZE - 1);
    localparam logic [5:0] FULL   = 6'(DECK_SIZE);

    state_t                 r_state, w_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [5:0]             r_last, r_cand;
    logic [DECK_SIZE-1:0]   r_mask;
    logic [5:0]             r_left, r_addr;
    logic [3:0]             r_rank;
    logic [1:0]             r_suit;
    logic                   r_empty, r_valid, r_err;

    logic [5:0]             w_step, w_seek_cand, w_next_cand;
    logic [6:0]             w_sum;
    logic                   w_hit;
    logic [3:0]             w_rank;
    logic [1:0]             w_suit;
    logic                   w_cnt_unused;

    // Upper counter bits only scramble timing history; the step uses [5:0].
    assign w_cnt_unused = ^r_cnt;

    assign w_step = bit_rev6(r_cnt[5:0]);
    assign w_sum  = {1'b0, r_last} + {1'b0, w_step};

    always_comb begin
        if (w_sum >= 7'd104)
            w_seek_cand = 6'(w_sum - 7'd104);
        else if (w_sum >= 7'd52)
            w_seek_cand = 6'(w_sum - 7'd52);
        else
            w_seek_cand = w_sum[5:0];
    end

    assign w_hit       = ~r_mask[r_cand];
    assign w_next_cand = (r_cand == LAST_A) ? 6'd0 : r_cand + 6'd1;

    card_decode u_decode (
        .i_addr (r_cand),
        .o_rank (w_rank),
        .o_suit (w_suit)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (Draw_Req && (r_left != 6'd0)) w_next = SEEK;
            SEEK:    w_next = PROBE;
            PROBE:   if (w_hit) w_next = DEAL;
            DEAL:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (New_Deck) w_next = IDLE;
    end

    always_ff @(posedge Clk) begin
        if (Rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt   <= '0;
            r_last  <= '0;
            r_cand  <= '0;
            r_mask  <= '0;
            r_left  <= FULL;
            r_empty <= 1'b0;
            r_addr  <= '0;
            r_rank  <= '0;
            r_suit  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (New_Deck) begin
                r_mask  <= '0;
                r_left  <= FULL;
                r_empty <= 1'b0;
            end else begin
                case (r_state)
                    IDLE:  if (Draw_Req && (r_left == 6'd0)) r_err <= 1'b1;
                    SEEK:  r_cand <= w_seek_cand;
                    PROBE: if (!w_hit) r_cand <= w_next_cand;
                    DEAL: begin
                        r_mask[r_cand] <= 1'b1;
                        r_last         <= r_cand;
                        r_left         <= r_left - 6'd1;
                        r_empty        <= (r_left == 6'd1);
                        r_addr         <= r_cand;
                        r_rank         <= w_rank;
                        r_suit         <= w_suit;
                        r_valid        <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Card_Valid = r_valid;
    assign Card_Addr  = r_addr;
    assign Card_Rank  = r_rank;
    assign Card_Suit  = r_suit;
    assign Cards_Left = r_left;
    assign Deck_Empty = r_empty;
    assign Busy       = (r_state != IDLE);
    assign Draw_Err   = r_err;
endmodule

// File: tb/tb_card_dealer.sv
// Directed self-checking bench for card_dealer with hand-computed draws.
module tb_card_dealer;
    logic       Clk = 1'b0;
    logic       Rst, New_Deck, Draw_Req;
    logic       Card_Valid, Deck_Empty, Busy, Draw_Err;
    logic [5:0] Card_Addr, Cards_Left;
    logic [3:0] Card_Rank;
    logic [1:0] Card_Suit;

    int total = 0;
    int bad   = 0;
    int c     = 0;

    card_dealer #(.CNT_W(12), .DECK_SIZE(52)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .New_Deck   (New_Deck),
        .Draw_Req   (Draw_Req),
        .Card_Valid (Card_Valid),
        .Card_Addr  (Card_Addr),
        .Card_Rank  (Card_Rank),
        .Card_Suit  (Card_Suit),
        .Cards_Left (Cards_Left),
        .Deck_Empty (Deck_Empty),
        .Busy       (Busy),
        .Draw_Err   (Draw_Err)
    );

    always #5 Clk = ~Clk;

    // Bench's own count of edges since reset release (expected Cnt value).
    always @(posedge Clk) begin
        if (Rst) c <= 0;
        else     c <= c + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_valid"}, Card_Valid, 0);
        check_eq({tag, "_addr"},  Card_Addr,  0);
        check_eq({tag, "_rank"},  Card_Rank,  0);
        check_eq({tag, "_suit"},  Card_Suit,  0);
        check_eq({tag, "_left"},  Cards_Left, 52);
        check_eq({tag, "_empty"}, Deck_Empty, 0);
        check_eq({tag, "_busy"},  Busy,       0);
        check_eq({tag, "_err"},   Draw_Err,   0);
    endtask

    // Request a draw so that SEEK sees Cnt[5:0]==t (t<0: request at once).
    // With extra set, Draw_Req is also held during SEEK/PROBE/DEAL.
    task automatic draw_at(input int t, input bit extra, output int lat, output bit got);
        int guard = 0;
        while (t >= 0 && ((c + 1) % 64) != t && guard < 200) begin
            @(negedge Clk);
            guard++;
        end
        Draw_Req = 1'b1;
        @(negedge Clk);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 80) begin
            Draw_Req = extra && (lat < 3);
            @(negedge Clk);
            lat++;
            if (Card_Valid) got = 1'b1;
        end
        Draw_Req = 1'b0;
    endtask

    task automatic draw_expect(input string tag, input int t, input bit extra,
                               input int e_lat, input int e_addr, input int e_rank,
                               input int e_suit, input int e_left);
        int lat;
        bit got;
        draw_at(t, extra, lat, got);
        check_eq({tag, "_got"},  got,        1);
        check_eq({tag, "_lat"},  lat,        e_lat);
        check_eq({tag, "_addr"}, Card_Addr,  e_addr);
        check_eq({tag, "_rank"}, Card_Rank,  e_rank);
        check_eq({tag, "_suit"}, Card_Suit,  e_suit);
        check_eq({tag, "_left"}, Cards_Left, e_left);
        check_eq({tag, "_err"},  Draw_Err,   0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat, vcnt;
        bit  got, ok;
        bit  seen [52];

        Rst = 1'b1; New_Deck = 1'b0; Draw_Req = 1'b0;
        repeat (3) @(negedge Clk);
        check_reset_vals("rst");

        // First draw: Cnt=1 -> step 32, Last=0 -> card 32
        Rst = 1'b0;
        draw_expect("first", 1, 1'b0, 3, 32, 7, 2, 51);
        check_eq("first_empty", Deck_Empty, 0);
        // Step 0 -> cand 32 dealt -> probe 33
        draw_expect("coll33", 0, 1'b0, 4, 33, 8, 2, 50);
        // 33 + 18 = 51
        draw_expect("set51", 18, 1'b0, 3, 51, 13, 3, 49);
        // 51 + 63 = 114 -> 10
        draw_expect("wrap", 63, 1'b0, 3, 10, 11, 0, 48);
        // 10 + 41 = 51 dealt -> wraps to 0
        draw_expect("coll0", 37, 1'b0, 4, 0, 1, 0, 47);
        // 0 + 40 = 40, with Draw_Req held while busy
        draw_expect("busyreq", 5, 1'b1, 3, 40, 2, 3, 46);
        vcnt = 0;
        repeat (6) begin
            @(negedge Clk);
            if (Card_Valid) vcnt++;
        end
        check_eq("busyreq_novalid", vcnt, 0);
        check_eq("busyreq_busy", Busy, 0);
        check_eq("busyreq_left", Cards_Left, 46);

        // New_Deck during PROBE aborts the draw
        Draw_Req = 1'b1;
        @(negedge Clk);
        Draw_Req = 1'b0;
        check_eq("nd_busy_seek", Busy, 1);
        @(negedge Clk);
        New_Deck = 1'b1;
        @(negedge Clk);
        New_Deck = 1'b0;
        check_eq("nd_valid", Card_Valid, 0);
        check_eq("nd_left",  Cards_Left, 52);
        check_eq("nd_empty", Deck_Empty, 0);
        check_eq("nd_busy",  Busy,       0);
        vcnt = 0;
        repeat (4) begin
            @(negedge Clk);
            if (Card_Valid) vcnt++;
        end
        check_eq("nd_novalid", vcnt, 0);
        draw_at(-1, 1'b0, lat, got);
        check_eq("nd_next_got",  got,        1);
        check_eq("nd_next_left", Cards_Left, 51);

        // Exhaustion: 52 unique cards
        New_Deck = 1'b1;
        @(negedge Clk);
        New_Deck = 1'b0;
        for (int i = 0; i < 52; i++) seen[i] = 1'b0;
        for (int i = 0; i < 52; i++) begin
            draw_at(-1, 1'b0, lat, got);
            ok = got && (Card_Addr < 6'd52);
            if (ok) begin
                ok = !seen[Card_Addr];
                seen[Card_Addr] = 1'b1;
            end
            check_eq("exh_unique", ok, 1);
            check_eq("exh_left", Cards_Left, 51 - i);
        end
        check_eq("exh_empty", Deck_Empty, 1);
        Draw_Req = 1'b1;
        @(negedge Clk);
        Draw_Req = 1'b0;
        check_eq("exh_err",   Draw_Err,   1);
        check_eq("exh_valid", Card_Valid, 0);
        check_eq("exh_busy",  Busy,       0);
        @(negedge Clk);
        check_eq("exh_err_end",  Draw_Err,   0);
        check_eq("exh_valid2",   Card_Valid, 0);
        check_eq("exh_busy2",    Busy,       0);
        check_eq("exh_left_end", Cards_Left, 0);

        // Rst with New_Deck and Draw_Req during PROBE
        New_Deck = 1'b1;
        @(negedge Clk);
        New_Deck = 1'b0;
        Draw_Req = 1'b1;
        @(negedge Clk);
        Draw_Req = 1'b0;
        @(negedge Clk);
        Rst = 1'b1; New_Deck = 1'b1; Draw_Req = 1'b1;
        @(negedge Clk);
        check_reset_vals("rstprobe");
        Rst = 1'b0; New_Deck = 1'b0; Draw_Req = 1'b0;
        // Cnt and Last_Addr both back at 0: same first card as after power-up
        draw_expect("postrst", 1, 1'b0, 3, 32, 7, 2, 51);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
Sequential dealer that draws cards from a 52-card deck without repetition. It consumes a pseudo-random next-address step and tracks which cards are already dealt. It serves the game FSM through a request/valid handshake and returns card rank, suit and address. It sits between the game controller and the deck/display logic.

Parameters:
CNT_W, 12, width of the internal free-running scramble counter (must be >= 6)
DECK_SIZE, 52, number of cards (addresses 0..DECK_SIZE-1; fixed at 52 for this design)

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous, active-high reset
New_Deck  in  1  one-cycle pulse; returns all cards to the deck
Draw_Req  in  1  one-cycle pulse; request one card
Card_Valid  out  1  one-cycle pulse; card outputs are valid
Card_Addr  out  6  dealt card address 0..51
Card_Rank  out  4  1..13 (1=Ace, 11..13=J,Q,K)
Card_Suit  out  2  0..3
Cards_Left  out  6  undealt cards, 0..52
Deck_Empty  out  1  high when Cards_Left==0
Busy  out  1  high in any state other than IDLE
Draw_Err  out  1  one-cycle pulse; Draw_Req received with an empty deck

Behaviour:
- Reset is synchronous on Clk; Rst has priority over every other input.
- Reset values:
  - Cnt=0, Last_Addr=0, Dealt_Mask=0, state=IDLE
  - Card_Valid=0, Card_Addr=0, Card_Rank=0, Card_Suit=0, Cards_Left=52, Deck_Empty=0, Busy=0, Draw_Err=0
- Cnt is a free-running CNT_W-bit counter that increments every cycle Rst is low and wraps naturally.
- States:
  - IDLE: Draw_Req with Cards_Left>0 -> SEEK. Draw_Req with Cards_Left==0 -> Draw_Err=1 for 1 cycle; stay IDLE.
  - SEEK (1 cycle):
    - Step = bit-reverse of Cnt[5:0], sampled in this cycle.
    - Sum = Last_Addr + Step, 7 bits wide.
    - Cand = Sum mod 52. Sum is at most 114, so subtract 104 if Sum>=104, else 52 if Sum>=52.
    - -> PROBE.
  - PROBE (1 cycle per probe):
    - Dealt_Mask[Cand]==0 -> DEAL.
    - Otherwise Cand = (Cand==51) ? 0 : Cand+1; stay in PROBE.
  - DEAL (1 cycle):
    - Set Dealt_Mask[Cand], Last_Addr=Cand, Cards_Left decrements by 1.
    - Card_Addr=Cand, Card_Suit=Cand/13, Card_Rank=(Cand mod 13)+1.
    - Card_Valid=1 -> IDLE.
- Latency:
  - Draw_Req sampled at edge t gives Card_Valid high in the cycle after edge t+3 when the first probe hits.
  - Each occupied probe adds 1 cycle. Worst case is 51 extra cycles.
  - Termination is guaranteed because Cards_Left>0.
- Card_Addr, Card_Rank and Card_Suit hold their last value between deals. Card_Valid is high only in the DEAL exit cycle.
- Draw_Req outside IDLE is ignored: no queueing, no error. The controller must wait for Busy=0.
- New_Deck (any state):
  - Dealt_Mask=0, Cards_Left=52, state=IDLE.
  - An in-progress draw is aborted with no Card_Valid.
  - Last_Addr and Cnt are kept.
  - New_Deck has priority over Draw_Req in the same cycle; that Draw_Req is dropped.
- Deck_Empty = (Cards_Left==0), driven from a register and updated together with Cards_Left.
- Draw_Err and Card_Valid are never high in the same cycle.

Decomposition:
- Shared package: DECK_SIZE=52, RANKS=13, SUITS=4, ADDR_W=6, and the dealer state enum (IDLE, SEEK, PROBE, DEAL).
- Sub-module card_decode (combinational): 6-bit address -> rank (1..13) and suit (0..3). It is reused by the display/score logic.
- The mod-52 step stays inline.

Test Plan:
- Release Rst, then pulse Draw_Req at the first edge. SEEK samples Cnt=1, so Step=32 -> Card_Valid with Card_Addr=32, Suit=2, Rank=7, Cards_Left=51, Card_Valid 3 cycles after the request edge.
- Wrap check: force a state with Last_Addr=51 and Step=63 -> Sum=114 -> Cand=10 -> Card_Addr=10, Suit=0, Rank=11.
- Collision: draw with Cand=32 already dealt and 33 free -> Card_Addr=33 with one extra cycle of latency. Cand=51 dealt and 0 free -> Card_Addr=0.
- Exhaustion: 52 consecutive draws -> all 52 addresses unique, Cards_Left=0, Deck_Empty=1. A 53rd Draw_Req -> Draw_Err pulse, no Card_Valid, state stays IDLE.
- New_Deck asserted in a PROBE cycle -> no Card_Valid, Cards_Left=52, Deck_Empty=0, Busy=0 on the next cycle. The next draw succeeds.
- Rst asserted during PROBE together with New_Deck and Draw_Req -> all outputs take their reset values on the next cycle and Cnt=0. Draw_Req pulses while Busy=1 are ignored and Cards_Left drops by exactly 1 per deal.
